pipelined_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 21 ++
 rtl/pipelined_addsub_if.sv | 26 ++
 rtl/addsub_chunk.sv | 23 ++
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 tb/tb_pipelined_addsub.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Op encodings, per-beat side-band bundle, operand extension.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic op_sub;
    logic is_signed;
  } sideband_t;

  // Extension bit placed above the operand MSB.
  function automatic logic ext_operand(
    input logic msb,
    input logic is_signed
  );
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// master drives operands and out_ready; slave is the unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             ovf;

  modport master (
    output in_valid, a, b, op_sub, is_signed, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, a, b, op_sub, is_signed, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit carry-ripple adder slice.
// One instance per pipeline stage.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub with exact WIDTH+1-bit result and overflow flag.
// Carry chain split over STAGES register stages, whole-pipe stall.
import addsub_pkg::*;

module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH < 2 || WIDTH % STAGES != 0) begin : g_bad
    $error("pipelined_addsub: bad WIDTH/STAGES");
  end

  logic           adv;
  sideband_t      sb_in;
  logic [WIDTH:0] ea;
  logic [WIDTH:0] eb;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  assign sb_in        = '{op_sub: bus.op_sub,
                          is_signed: bus.is_signed};
  assign ea = {ext_operand(bus.a[WIDTH-1], bus.is_signed), bus.a};
  assign eb = {ext_operand(bus.b[WIDTH-1], bus.is_signed), bus.b};

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int LO = s * CHUNK;

    logic [WIDTH-LO:0]     ai;
    logic [WIDTH-LO:0]     bi;
    logic                  ci;
    logic                  vi;
    logic                  co;
    sideband_t             sbi;
    logic [CHUNK-1:0]      bx;
    logic [CHUNK-1:0]      sum;
    logic [LO+CHUNK-1:0]   rn;

    if (s == 0) begin : g_src
      assign ai  = ea;
      assign bi  = eb;
      assign sbi = sb_in;
      assign vi  = bus.in_valid;
      assign ci  = (sb_in.op_sub == OP_SUB);
      assign rn  = sum;
    end else begin : g_src
      assign ai  = stg[s-1].g_mid.a_q;
      assign bi  = stg[s-1].g_mid.b_q;
      assign sbi = stg[s-1].g_mid.sb_q;
      assign vi  = stg[s-1].g_mid.v_q;
      assign ci  = stg[s-1].g_mid.c_q;
      assign rn  = {sum, stg[s-1].g_mid.r_q};
    end

    // Subtraction inverts B one chunk at a time as it arrives.
    assign bx = bi[CHUNK-1:0] ^ {CHUNK{sbi.op_sub}};

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (ai[CHUNK-1:0]),
      .b  (bx),
      .ci (ci),
      .s  (sum),
      .co (co)
    );

    if (s < STAGES - 1) begin : g_mid
      logic [WIDTH-LO-CHUNK:0] a_q;
      logic [WIDTH-LO-CHUNK:0] b_q;
      logic [LO+CHUNK-1:0]     r_q;
      logic                    c_q;
      logic                    v_q;
      sideband_t               sb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          r_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
          sb_q <= '0;
        end else if (adv) begin
          a_q  <= ai[WIDTH-LO:CHUNK];
          b_q  <= bi[WIDTH-LO:CHUNK];
          r_q  <= rn;
          c_q  <= co;
          v_q  <= vi;
          sb_q <= sbi;
        end
      end
    end else begin : g_last
      logic           msb;
      logic [WIDTH:0] r_q;
      logic           ovf_q;
      logic           v_q;

      assign msb = ai[CHUNK] ^ bi[CHUNK] ^ sbi.op_sub ^ co;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q   <= '0;
          ovf_q <= 1'b0;
          v_q   <= 1'b0;
        end else if (adv) begin
          r_q   <= {msb, rn};
          ovf_q <= sbi.is_signed ? (msb ^ rn[WIDTH-1]) : msb;
          v_q   <= vi;
        end
      end
    end
  end

  assign bus.out_valid = stg[STAGES-1].g_last.v_q;
  assign bus.result    = stg[STAGES-1].g_last.r_q;
  assign bus.ovf       = stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub, WIDTH=4 STAGES=2.
// Immediate assertions at every comparison point.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(4)) bus ();

  pipelined_addsub #(.WIDTH(4), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] bta [8] = '{4'd3, 4'd15, 4'd8, 4'd7,
                          4'd0, 4'd9, 4'd12, 4'd1};
  logic [3:0] btb [8] = '{4'd5, 4'd1, 4'd8, 4'd7,
                          4'd1, 4'd6, 4'd4, 4'd14};
  logic       bsb [8] = '{1'b1, 1'b0, 1'b0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0};
  logic       bsg [8] = '{1'b0, 1'b1, 1'b1, 1'b0,
                          1'b1, 1'b0, 1'b1, 1'b1};

  // Reference: integer arithmetic plus range test for overflow.
  function automatic logic [5:0] mdl(
    input logic [3:0] a, input logic [3:0] b,
    input logic sub, input logic sgn
  );
    int ia, ib, r;
    logic [31:0] rv;
    logic o;
    ia = sgn ? int'(signed'(a)) : int'(a);
    ib = sgn ? int'(signed'(b)) : int'(b);
    r  = sub ? ia - ib : ia + ib;
    rv = r;
    o  = sgn ? (r < -8 || r > 7) : (r < 0 || r > 15);
    return {o, rv[4:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic sub,
                       input logic sgn);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.op_sub    = sub;
    bus.is_signed = sgn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one(input string tag, input logic [3:0] a,
                     input logic [3:0] b, input logic sub,
                     input logic sgn, input logic [4:0] er,
                     input logic eo);
    drive(1'b1, a, b, sub, sgn);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk({tag, "_early"}, 8'(bus.out_valid), 8'd0);
    tick();
    chk({tag, "_vld"}, 8'(bus.out_valid), 8'd1);
    chk({tag, "_res"}, 8'(bus.result), 8'(er));
    chk({tag, "_ovf"}, 8'(bus.ovf), 8'(eo));
    tick();
  endtask

  initial begin
    logic [5:0] e;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #2;
    chk("rst_vld", 8'(bus.out_valid), 8'd0);
    chk("rst_res", 8'(bus.result), 8'd0);
    chk("rst_ovf", 8'(bus.ovf), 8'd0);
    chk("rst_rdy", 8'(bus.in_ready), 8'd1);
    tick();
    tick();
    rst_n = 1'b1;

    one("usub_3_5",  4'd3,  4'd5,  1'b1, 1'b0, 5'b11110, 1'b1);
    one("ssub_m8_1", 4'h8,  4'h1,  1'b1, 1'b1, 5'b10111, 1'b1);
    one("sadd_3_m2", 4'h3,  4'hE,  1'b0, 1'b1, 5'b00001, 1'b0);
    one("uadd_15",   4'd15, 4'd15, 1'b0, 1'b0, 5'b11110, 1'b1);
    one("uadd_7_8",  4'd7,  4'd8,  1'b0, 1'b0, 5'b01111, 1'b0);
    one("ssub_7_m8", 4'h7,  4'h8,  1'b1, 1'b1, 5'b01111, 1'b1);
    one("usub_5_3",  4'd5,  4'd3,  1'b1, 1'b0, 5'b00010, 1'b0);
    one("sadd_m8m8", 4'h8,  4'h8,  1'b0, 1'b1, 5'b10000, 1'b1);

    // Back-to-back: beat i presented in cycle i, shows after edge i+1.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1'b1, bta[c], btb[c], bsb[c], bsg[c]);
      else drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      tick();
      chk("b2b_rdy", 8'(bus.in_ready), 8'd1);
      if (c >= 1 && c <= 8) begin
        e = mdl(bta[c-1], btb[c-1], bsb[c-1], bsg[c-1]);
        chk("b2b_vld", 8'(bus.out_valid), 8'd1);
        chk("b2b_res", 8'(bus.result), 8'(e[4:0]));
        chk("b2b_ovf", 8'(bus.ovf), 8'(e[5]));
      end else begin
        chk("b2b_idle", 8'(bus.out_valid), 8'd0);
      end
    end

    // Backpressure with beats 0,1 in flight and beat 2 waiting.
    drive(1'b1, bta[0], btb[0], bsb[0], bsg[0]);
    tick();
    drive(1'b1, bta[1], btb[1], bsb[1], bsg[1]);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, bta[2], btb[2], bsb[2], bsg[2]);
    #1;
    chk("bp_rdy0", 8'(bus.in_ready), 8'd0);
    e = mdl(bta[0], btb[0], bsb[0], bsg[0]);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_rdy", 8'(bus.in_ready), 8'd0);
      chk("bp_vld", 8'(bus.out_valid), 8'd1);
      chk("bp_res", 8'(bus.result), 8'(e[4:0]));
      chk("bp_ovf", 8'(bus.ovf), 8'(e[5]));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 8'(bus.in_ready), 8'd1);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int c = 1; c < 3; c++) begin
      e = mdl(bta[c], btb[c], bsb[c], bsg[c]);
      chk("bp_out_vld", 8'(bus.out_valid), 8'd1);
      chk("bp_out_res", 8'(bus.result), 8'(e[4:0]));
      tick();
    end
    chk("bp_drain", 8'(bus.out_valid), 8'd0);

    // Reset with two beats in flight.
    drive(1'b1, bta[3], btb[3], bsb[3], bsg[3]);
    tick();
    drive(1'b1, bta[4], btb[4], bsb[4], bsg[4]);
    tick();
    chk("pre_rst_vld", 8'(bus.out_valid), 8'd1);
    drive(1'b1, bta[5], btb[5], bsb[5], bsg[5]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 8'(bus.out_valid), 8'd0);
    chk("mid_rst_res", 8'(bus.result), 8'd0);
    chk("mid_rst_ovf", 8'(bus.ovf), 8'd0);
    chk("mid_rst_rdy", 8'(bus.in_ready), 8'd1);
    tick();
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 8'(bus.out_valid), 8'd0);
    drive(1'b1, bta[6], btb[6], bsb[6], bsg[6]);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("post_rst_early", 8'(bus.out_valid), 8'd0);
    tick();
    e = mdl(bta[6], btb[6], bsb[6], bsg[6]);
    chk("post_rst_vld", 8'(bus.out_valid), 8'd1);
    chk("post_rst_res", 8'(bus.result), 8'(e[4:0]));
    chk("post_rst_ovf", 8'(bus.ovf), 8'(e[5]));
    tick();
    chk("post_rst_alone", 8'(bus.out_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
